// File: rtl/sccb_pkg.sv
// Shared types and constants for the OV7670 SCCB bring-up sequencer.
// Latency: n/a (types only); backpressure: n/a.
package sccb_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_START, S_WAIT, S_GAP, S_DELAY, S_NEXT, S_DONE
  } state_e;

  localparam logic [15:0] SCCB_MARK_END   = 16'hFFFF;
  localparam logic [15:0] SCCB_MARK_DELAY = 16'hFFF0;
  localparam logic [7:0]  OV7670_WR_ID    = 8'h42;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } entry_t;

  // Width of a down-counter able to hold the largest of three cycle counts.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    int unsigned w;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    w = $clog2(m + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // A wait of n cycles loads n-1; a zero-length wait still takes one cycle.
  function automatic int unsigned cycles_m1(input int unsigned n);
    return (n == 0) ? 0 : n - 1;
  endfunction

endpackage

// File: rtl/ov7670_reg_rom.sv
// OV7670 register table as a synchronous case ROM; entries are {addr, data} or a marker.
// Latency: 1 cycle from addr to data; no backpressure.
module ov7670_reg_rom
  import sccb_pkg::*;
#(
  parameter int unsigned ROM_AW = 8
) (
  input  logic              clk,
  input  logic [ROM_AW-1:0] addr,
  output logic [15:0]       data
);

  logic [15:0] data_q;

  // Soft reset, settle delay, clock prescaler; unlisted slots read as END.
  always_ff @(posedge clk) begin
    case (32'(addr))
      32'd0:   data_q <= {8'h12, 8'h80};
      32'd1:   data_q <= SCCB_MARK_DELAY;
      32'd2:   data_q <= {8'h11, 8'h01};
      default: data_q <= SCCB_MARK_END;
    endcase
  end

  assign data = data_q;

endmodule

// File: rtl/sccb_init_sequencer.sv
// Walks the OV7670 table and issues one SCCB write per entry; `SCCB_RETRY_EN adds per-entry retry on i_sccb_err.
// Latency: strobe 3 cycles after leaving IDLE/DONE; waits for i_sccb_done (bounded by TIMEOUT_CYCLES).
module sccb_init_sequencer
  import sccb_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ    = 100_000_000,
  parameter logic [7:0]  DEV_ID         = OV7670_WR_ID,
  parameter int unsigned ROM_AW         = 8,
  parameter int unsigned GAP_CYCLES     = 1000,
  parameter int unsigned DELAY_MS       = 10,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
  parameter int unsigned MAX_RETRY      = 3,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_start,
  input  logic              i_sccb_done,
  input  logic              i_sccb_err,
  output logic              o_sccb_start,
  output logic [23:0]       o_sccb_word,
  output logic              o_busy,
  output logic              o_init_done,
  output logic              o_error,
  output logic [ROM_AW-1:0] o_index
);

  localparam int unsigned DELAY_CYC = DELAY_MS * (CLK_FREQ_HZ / 1000);
  localparam int unsigned CNT_W     = cnt_width(DELAY_CYC, TIMEOUT_CYCLES, GAP_CYCLES);
  localparam logic [CNT_W-1:0] DELAY_LD   = CNT_W'(cycles_m1(DELAY_CYC));
  localparam logic [CNT_W-1:0] GAP_LD     = CNT_W'(cycles_m1(GAP_CYCLES));
  localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(cycles_m1(TIMEOUT_CYCLES));

  state_e            state_q, state_d;
  logic [ROM_AW-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [23:0]       word_q, word_d;
  logic              init_done_q, init_done_d;
  logic              error_q, error_d;
  logic              auto_q, auto_d;
  logic [15:0]       rom_dat;
  entry_t            rom_ent;

  ov7670_reg_rom #(.ROM_AW(ROM_AW)) u_rom (
    .clk  (clk),
    .addr (idx_q),
    .data (rom_dat)
  );

  assign rom_ent = entry_t'(rom_dat);

`ifdef SCCB_RETRY_EN
  localparam int unsigned RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RTY_W-1:0] rty_q, rty_d;
  logic             redo_q, redo_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rty_q  <= '0;
      redo_q <= 1'b0;
    end else begin
      rty_q  <= rty_d;
      redo_q <= redo_d;
    end
  end
`else
  localparam int unsigned unused_max_retry = MAX_RETRY;
  logic unused_err;
  assign unused_err = i_sccb_err;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      word_q      <= '0;
      init_done_q <= 1'b0;
      error_q     <= 1'b0;
      auto_q      <= AUTO_START;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      init_done_q <= init_done_d;
      error_q     <= error_d;
      auto_q      <= auto_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    word_d       = word_q;
    init_done_d  = init_done_q;
    error_d      = error_q;
    auto_d       = auto_q;
    o_sccb_start = 1'b0;
    o_busy       = 1'b1;
`ifdef SCCB_RETRY_EN
    rty_d        = rty_q;
    redo_d       = redo_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        o_busy = 1'b0;
        // The power-up auto run only applies to IDLE and fires once per reset.
        if (i_start || (auto_q && state_q == S_IDLE)) begin
          auto_d      = 1'b0;
          idx_d       = '0;
          init_done_d = 1'b0;
          error_d     = 1'b0;
          state_d     = S_FETCH;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
`ifdef SCCB_RETRY_EN
        rty_d  = '0;
        redo_d = 1'b0;
`endif
        if (rom_dat == SCCB_MARK_END) begin
          init_done_d = 1'b1;
          state_d     = S_DONE;
        end else if (rom_dat == SCCB_MARK_DELAY) begin
          cnt_d   = DELAY_LD;
          state_d = S_DELAY;
        end else begin
          word_d  = {DEV_ID, rom_ent.addr, rom_ent.data};
          state_d = S_START;
        end
      end
      S_START: begin
        o_sccb_start = 1'b1;
        cnt_d        = TIMEOUT_LD;
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        // A done arriving in the last timeout cycle still wins.
        if (i_sccb_done) begin
          cnt_d   = GAP_LD;
          state_d = S_GAP;
`ifdef SCCB_RETRY_EN
          redo_d  = i_sccb_err;
          if (i_sccb_err) begin
            if (rty_q == RTY_W'(MAX_RETRY)) begin
              error_d = 1'b1;
              state_d = S_DONE;
            end else begin
              rty_d = rty_q + 1'b1;
            end
          end
`endif
        end else if (cnt_q == '0) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
`ifdef SCCB_RETRY_EN
          state_d = redo_q ? S_START : S_NEXT;
`else
          state_d = S_NEXT;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DELAY: begin
        if (cnt_q == '0) state_d = S_NEXT;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_NEXT: begin
        if (idx_q == {ROM_AW{1'b1}}) begin
          init_done_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_sccb_word = word_q;
  assign o_init_done = init_done_q;
  assign o_error     = error_q;
  assign o_index     = idx_q;

endmodule
